// File: rtl/mezcla_pkg.sv
// ---------------------------------------------------------------------------
// mezcla_pkg
// Shared definitions for the mixer input-conditioning stage.
//   DEB_N_DEF / T_TOK_DEF / CW_DEF : default debounce length, token period
//                                    and counter width.
//   timer_state_t                  : token timer state encoding.
// ---------------------------------------------------------------------------
package mezcla_pkg;

    localparam int DEB_N_DEF = 4;
    localparam int T_TOK_DEF = 1000;
    localparam int CW_DEF    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } timer_state_t;

endpackage : mezcla_pkg

// File: rtl/antirrebote.sv
// ---------------------------------------------------------------------------
// antirrebote
// Two-flop synchronizer followed by a counting debouncer for one raw input.
// The debounced level only follows the synchronized input after DEB_N
// consecutive synchronized samples that disagree with it.
//   i_clk    : system clock, rising edge
//   i_reset  : synchronous, active-high reset
//   i_raw    : asynchronous raw input
//   o_sync   : synchronized input (second flop)
//   o_level  : debounced, registered level
// ---------------------------------------------------------------------------
module antirrebote
    import mezcla_pkg::*;
#(
    parameter int DEB_N = DEB_N_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_sync,
    output logic o_level
);

    localparam logic [CW-1:0] DC_LAST = CW'(DEB_N - 1);
    localparam logic [CW-1:0] DC_ONE  = CW'(1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_dc;

    // NOTE: every flop here is updated with <= so all of them sample the
    // values from before the edge; blocking writes would collapse the
    // synchronizer into a single stage.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_dc    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                // Agreement at any point restarts the stability window.
                r_dc <= '0;
            end else if (r_dc == DC_LAST) begin
                // DEB_N-th consecutive disagreeing sample: accept the level.
                r_level <= r_sync;
                r_dc    <= '0;
            end else begin
                r_dc <= r_dc + DC_ONE;
            end
        end
    end

    assign o_sync  = r_sync;
    assign o_level = r_level;

endmodule : antirrebote

// File: rtl/acondicionador_entradas.sv
// ---------------------------------------------------------------------------
// acondicionador_entradas
// Conditions the start button and the two level sensors for the mixer, turns
// the button into a one-shot start pulse and generates periodic time tokens
// while the mixer runs. All outputs are registered.
//   Clk     : system clock, rising edge
//   Reset   : synchronous, active-high reset
//   BtnRaw  : raw start push-button
//   P1Raw   : raw level sensor 1
//   P2Raw   : raw level sensor 2
//   Run     : timer enable (mixer S output)
//   IN      : one-cycle start pulse
//   P1, P2  : debounced sensor levels
//   TOK     : one-cycle time token, every T_TOK Run cycles
//   TokCnt  : tokens issued since Run rose, saturating at 3
// ---------------------------------------------------------------------------
module acondicionador_entradas
    import mezcla_pkg::*;
#(
    parameter int DEB_N = DEB_N_DEF,
    parameter int T_TOK = T_TOK_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnRaw,
    input  logic       P1Raw,
    input  logic       P2Raw,
    input  logic       Run,
    output logic       IN,
    output logic       P1,
    output logic       P2,
    output logic       TOK,
    output logic [1:0] TokCnt
);

    localparam logic [CW-1:0] CNT_LAST = CW'(T_TOK - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic w_btn_sync;
    logic w_btn_db;
    logic w_p1_sync;
    logic w_p2_sync;
    logic w_unused_sync;

    // ------------------------------------------------------------------
    // Input conditioning: one synchronizer + debouncer per raw input.
    // ------------------------------------------------------------------
    antirrebote #(.DEB_N(DEB_N), .CW(CW)) u_btn (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_raw   (BtnRaw),
        .o_sync  (w_btn_sync),
        .o_level (w_btn_db)
    );

    antirrebote #(.DEB_N(DEB_N), .CW(CW)) u_p1 (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_raw   (P1Raw),
        .o_sync  (w_p1_sync),
        .o_level (P1)
    );

    antirrebote #(.DEB_N(DEB_N), .CW(CW)) u_p2 (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_raw   (P2Raw),
        .o_sync  (w_p2_sync),
        .o_level (P2)
    );

    // The sensors only need their debounced level.
    assign w_unused_sync = w_p1_sync ^ w_p2_sync;

    // ------------------------------------------------------------------
    // Start one-shot.
    // ------------------------------------------------------------------
    logic [1:0] r_valid;
    logic       r_btn_prev;
    logic       r_armed;
    logic       r_in;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid    <= '0;
            r_btn_prev <= 1'b0;
            r_armed    <= 1'b0;
            r_in       <= 1'b0;
        end else begin
            // r_valid[1] marks that the synchronizer holds a real sample
            // rather than the zeros left behind by reset.
            r_valid    <= {r_valid[0], 1'b1};
            r_btn_prev <= w_btn_db;
            // Arm only on a genuinely released button, so a button held
            // through reset cannot fire until it is released and pressed.
            if (r_valid[1] && !w_btn_sync && !w_btn_db) begin
                r_armed <= 1'b1;
            end
            r_in <= r_armed && w_btn_db && !r_btn_prev;
        end
    end

    assign IN = r_in;

    // ------------------------------------------------------------------
    // Token timer FSM.
    // ------------------------------------------------------------------
    timer_state_t  r_state;
    logic [CW-1:0] r_count;
    logic          r_tok;
    logic [1:0]    r_tokcnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_tok    <= 1'b0;
            r_tokcnt <= '0;
        end else begin
            r_tok <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Run) begin
                        r_state <= ST_COUNT;
                        if (T_TOK == 1) begin
                            // A one-cycle period tokens on the first sample.
                            r_tok    <= 1'b1;
                            r_count  <= '0;
                            r_tokcnt <= 2'd1;
                        end else begin
                            r_count <= CNT_ONE;
                        end
                    end else begin
                        r_count  <= '0;
                        r_tokcnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (!Run) begin
                        // Dropping Run wins over a terminal count.
                        r_state  <= ST_IDLE;
                        r_count  <= '0;
                        r_tokcnt <= '0;
                    end else if (r_count == CNT_LAST) begin
                        r_tok   <= 1'b1;
                        r_count <= '0;
                        if (r_tokcnt != 2'd3) begin
                            r_tokcnt <= r_tokcnt + 2'd1;
                        end
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_count  <= '0;
                    r_tokcnt <= '0;
                end
            endcase
        end
    end

    assign TOK    = r_tok;
    assign TokCnt = r_tokcnt;

endmodule : acondicionador_entradas

// File: tb/tb_acondicionador_entradas.sv
// ---------------------------------------------------------------------------
// tb_acondicionador_entradas
// Self-checking bench for acondicionador_entradas with DEB_N = 4, T_TOK = 10.
// Directed scenarios check the documented timing points; a randomized run
// compares every output against a behavioural model each cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acondicionador_entradas;

    localparam int DEB_N = 4;
    localparam int T_TOK = 10;
    localparam int CW    = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       BtnRaw = 1'b0;
    logic       P1Raw = 1'b0;
    logic       P2Raw = 1'b0;
    logic       Run = 1'b0;
    logic       IN;
    logic       P1;
    logic       P2;
    logic       TOK;
    logic [1:0] TokCnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    acondicionador_entradas #(.DEB_N(DEB_N), .T_TOK(T_TOK), .CW(CW)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .BtnRaw (BtnRaw),
        .P1Raw  (P1Raw),
        .P2Raw  (P2Raw),
        .Run    (Run),
        .IN     (IN),
        .P1     (P1),
        .P2     (P2),
        .TOK    (TOK),
        .TokCnt (TokCnt)
    );

    // ------------------------------------------------------------------
    // Behavioural model. Channel 0 = button, 1 = P1, 2 = P2.
    // A channel's debounced level flips once the last DEB_N synchronized
    // samples all disagree with it; a synchronized sample is the raw value
    // from two edges earlier. Tokens follow from the number of consecutive
    // Run samples: one every T_TOK samples, TokCnt = min(samples/T_TOK, 3).
    // ------------------------------------------------------------------
    logic       m_hist [3][2];
    logic       m_win  [3][DEB_N];
    logic       m_lvl  [3];
    logic       m_armed;
    logic       m_rose;
    logic       m_in;
    logic       m_tok;
    logic [1:0] m_tokcnt;
    int         m_edges;
    int         m_run_n;

    task automatic model_edge(input logic rst, input logic btn, input logic p1,
                              input logic p2, input logic run);
        logic raw [3];
        logic s   [3];
        logic btn_pre;
        logic all_diff;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_hist[c][0] = 1'b0;
                m_hist[c][1] = 1'b0;
                for (int i = 0; i < DEB_N; i++) m_win[c][i] = 1'b0;
                m_lvl[c] = 1'b0;
            end
            m_armed  = 1'b0;
            m_rose   = 1'b0;
            m_in     = 1'b0;
            m_tok    = 1'b0;
            m_tokcnt = 2'd0;
            m_edges  = 0;
            m_run_n  = 0;
            return;
        end
        raw[0] = btn;
        raw[1] = p1;
        raw[2] = p2;
        btn_pre = m_lvl[0];
        for (int c = 0; c < 3; c++) begin
            s[c] = m_hist[c][1];
            m_hist[c][1] = m_hist[c][0];
            m_hist[c][0] = raw[c];
        end
        // Start pulse: the edge after a debounced rise, only when armed.
        m_in = m_rose && m_armed;
        // Armed by the first genuine released sample (not reset fill).
        if (m_edges >= 2 && !s[0] && !btn_pre) m_armed = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < DEB_N - 1; i++) m_win[c][i] = m_win[c][i+1];
            m_win[c][DEB_N-1] = s[c];
            all_diff = 1'b1;
            for (int i = 0; i < DEB_N; i++) if (m_win[c][i] == m_lvl[c]) all_diff = 1'b0;
            if (all_diff) m_lvl[c] = ~m_lvl[c];
        end
        m_rose = !btn_pre && m_lvl[0];
        m_edges++;
        if (run) begin
            m_run_n++;
            m_tok    = (m_run_n % T_TOK) == 0;
            m_tokcnt = (m_run_n / T_TOK >= 3) ? 2'd3 : 2'(m_run_n / T_TOK);
        end else begin
            m_run_n  = 0;
            m_tok    = 1'b0;
            m_tokcnt = 2'd0;
        end
    endtask

    // Drive one cycle of inputs, let the DUT sample them, advance the model
    // and return at the following falling edge where outputs are stable.
    task automatic step(input logic rst, input logic btn, input logic p1,
                        input logic p2, input logic run);
        Reset  = rst;
        BtnRaw = btn;
        P1Raw  = p1;
        P2Raw  = p2;
        Run    = run;
        @(posedge Clk);
        model_edge(rst, btn, p1, p2, run);
        @(negedge Clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (IN !== 1'b0) begin tests_failed++; $display("FAIL reset_IN got=%b exp=0", IN); end
        tests_run++;
        if (P1 !== 1'b0) begin tests_failed++; $display("FAIL reset_P1 got=%b exp=0", P1); end
        tests_run++;
        if (P2 !== 1'b0) begin tests_failed++; $display("FAIL reset_P2 got=%b exp=0", P2); end
        tests_run++;
        if (TOK !== 1'b0) begin tests_failed++; $display("FAIL reset_TOK got=%b exp=0", TOK); end
        tests_run++;
        if (TokCnt !== 2'd0) begin tests_failed++; $display("FAIL reset_TokCnt got=%0d exp=0", TokCnt); end
    endtask

    task automatic test_sensor_debounce();
        logic exp_p1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            exp_p1 = (k >= DEB_N + 1);
            tests_run++;
            if (P1 !== exp_p1) begin
                tests_failed++;
                $display("FAIL debounce_P1 edge=%0d got=%b exp=%b", k, P1, exp_p1);
            end
            tests_run++;
            if (P2 !== 1'b0) begin
                tests_failed++;
                $display("FAIL debounce_P2 edge=%0d got=%b exp=0", k, P2);
            end
        end
    endtask

    task automatic test_glitch();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            step(1'b0, 1'b0, 1'b0, (k < 3), 1'b0);
            tests_run++;
            if (P2 !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_P2 edge=%0d got=%b exp=0", k, P2);
            end
        end
        tests_run++;
        if (dut.u_p2.r_dc !== '0) begin
            tests_failed++;
            $display("FAIL glitch_dc got=%0d exp=0", dut.u_p2.r_dc);
        end
    endtask

    task automatic test_start_pulse();
        logic exp_in;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_in = (k == DEB_N + 2);
            tests_run++;
            if (IN !== exp_in) begin
                tests_failed++;
                $display("FAIL start_IN edge=%0d got=%b exp=%b", k, IN, exp_in);
            end
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tests_run++;
            if (IN !== 1'b0) begin
                tests_failed++;
                $display("FAIL release_IN edge=%0d got=%b exp=0", k, IN);
            end
        end
    endtask

    task automatic test_held_through_reset();
        int pulses;
        logic exp_in;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tests_run++;
            if (IN !== 1'b0) begin
                tests_failed++;
                $display("FAIL held_IN edge=%0d got=%b exp=0", k, IN);
            end
        end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (IN === 1'b1) pulses++;
            exp_in = (k == DEB_N + 2);
            tests_run++;
            if (IN !== exp_in) begin
                tests_failed++;
                $display("FAIL repress_IN edge=%0d got=%b exp=%b", k, IN, exp_in);
            end
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL repress_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_token_train();
        logic       exp_tok;
        logic [1:0] exp_cnt;
        int         toks;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        toks = 0;
        for (int k = 0; k < 45; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_tok = ((k + 1) % T_TOK) == 0;
            exp_cnt = ((k + 1) / T_TOK >= 3) ? 2'd3 : 2'((k + 1) / T_TOK);
            if (TOK === 1'b1) toks++;
            tests_run++;
            if (TOK !== exp_tok) begin
                tests_failed++;
                $display("FAIL train_TOK edge=%0d got=%b exp=%b", k, TOK, exp_tok);
            end
            tests_run++;
            if (TokCnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL train_TokCnt edge=%0d got=%0d exp=%0d", k, TokCnt, exp_cnt);
            end
        end
        tests_run++;
        if (toks != 4) begin
            tests_failed++;
            $display("FAIL train_count got=%0d exp=4", toks);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (TokCnt !== 2'd0 || TOK !== 1'b0) begin
            tests_failed++;
            $display("FAIL train_drop got TokCnt=%0d TOK=%b exp TokCnt=0 TOK=0", TokCnt, TOK);
        end
    endtask

    task automatic test_run_drop_and_reset();
        logic exp_tok;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < T_TOK - 1; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (TOK !== 1'b0 || TokCnt !== 2'd0) begin
            tests_failed++;
            $display("FAIL terminal_drop got TOK=%b TokCnt=%0d exp TOK=0 TokCnt=0", TOK, TokCnt);
        end
        for (int k = 0; k < T_TOK; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            exp_tok = (k == T_TOK - 1);
            tests_run++;
            if (TOK !== exp_tok) begin
                tests_failed++;
                $display("FAIL rerun_TOK edge=%0d got=%b exp=%b", k, TOK, exp_tok);
            end
        end
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (P1 !== 1'b1 || P2 !== 1'b1 || TokCnt !== 2'd1) begin
            tests_failed++;
            $display("FAIL pre_reset got P1=%b P2=%b TokCnt=%0d exp P1=1 P2=1 TokCnt=1",
                     P1, P2, TokCnt);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if ({IN, P1, P2, TOK, TokCnt} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got IN=%b P1=%b P2=%b TOK=%b TokCnt=%0d exp all 0",
                     IN, P1, P2, TOK, TokCnt);
        end
    endtask

    task automatic test_random();
        logic btn, p1, p2, run, rst;
        btn = 1'b0;
        p1  = 1'b0;
        p2  = 1'b0;
        run = 1'b0;
        step(1'b1, btn, p1, p2, run);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) btn = ~btn;
            if ($urandom_range(0, 7) == 0) p1  = ~p1;
            if ($urandom_range(0, 5) == 0) p2  = ~p2;
            if ($urandom_range(0, 29) == 0) run = ~run;
            rst = ($urandom_range(0, 249) == 0);
            step(rst, btn, p1, p2, run);
            tests_run++;
            if ({IN, P1, P2, TOK, TokCnt} !== {m_in, m_lvl[1], m_lvl[2], m_tok, m_tokcnt}) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got IN=%b P1=%b P2=%b TOK=%b TokCnt=%0d exp IN=%b P1=%b P2=%b TOK=%b TokCnt=%0d",
                         i, IN, P1, P2, TOK, TokCnt, m_in, m_lvl[1], m_lvl[2], m_tok, m_tokcnt);
            end
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_sensor_debounce();
        test_glitch();
        test_start_pulse();
        test_held_through_reset();
        test_token_train();
        test_run_drop_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_acondicionador_entradas

// File: doc/acondicionador_entradas.md
# acondicionador_entradas

Input-conditioning and timing stage in front of the mixer controller. It synchronizes and debounces the raw start button and the two level sensors, and converts the button into a one-shot start pulse `IN`. While the mixer signals it is mixing, it generates the periodic `TOK` time-token pulses. Every output is registered and feeds the mixer's `IN`, `P1`, `P2` and `TOK` inputs directly.

## Interface
Parameters:
- `DEB_N`, default 4: consecutive stable synchronized cycles required before a debounced level changes. Must be ≥ 1.
- `T_TOK`, default 1000: `Run` cycles per `TOK` period. Must be ≥ 1.
- `CW`, default 16: counter width. Must hold max(`DEB_N`, `T_TOK`).

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `BtnRaw`  in  1  asynchronous start push-button.
- `P1Raw`, `P2Raw`  in  1  asynchronous level sensors.
- `Run`  in  1  timer enable, driven by the mixer's `S` output.
- `IN`  out  1  one-cycle start pulse.
- `P1`, `P2`  out  1  debounced sensor levels.
- `TOK`  out  1  one-cycle time token.
- `TokCnt`  out  2  tokens issued since `Run` rose, saturating at 3.

## Operation
- **Reset:** clears all synchronizer flops, debounced levels, counters, `IN`, `TOK` and `TokCnt` to 0. It also clears the button arm flag and puts the timer in IDLE.
- **Synchronizer:** two flops per raw input.
- **Debouncer (per channel):**
  - Counter `dc` clears whenever the synchronized input equals the debounced output.
  - Otherwise `dc` increments.
  - When `dc` = `DEB_N`−1 and the inputs still differ, the output flips and `dc` clears.
  - Any excursion shorter than `DEB_N` synchronized cycles is ignored.
- **Start one-shot:**
  - The arm flag sets the first time the debounced button is seen at 0 after reset.
  - `IN` is registered. It is 1 for exactly one cycle, the cycle after a debounced 0→1 transition, and only while armed.
  - No pulse on release. Holding the button produces one pulse.
  - A button held through reset produces no pulse until it is released and pressed again.
- **Timer FSM:**
  - IDLE:
    - Holds count = 0, `TOK` = 0, `TokCnt` = 0.
    - `Run` sampled 1 → COUNT, with count = 1.
    - If `T_TOK` = 1, issues `TOK` immediately.
  - COUNT:
    - Each `Run` = 1 sample increments count.
    - On the `T_TOK`-th consecutive sample: `TOK` ← 1 for one cycle, count ← 0, `TokCnt` ← min(`TokCnt`+1, 3).
    - `Run` sampled 0 → IDLE, count, `TOK` and `TokCnt` cleared.
- **Simultaneous events:**
  - `Run` = 0 in the terminal cycle: no `TOK` (`Run` wins).
  - Raising `Run` again restarts a full period.
- **Arithmetic:** counters are unsigned `CW`-bit. The timer count never exceeds `T_TOK`−1 and never wraps.

## Timing
- Edge 0 is the first rising edge that samples a new raw level.
- Debounced `P1`/`P2`/button change after edge `DEB_N`+1 if the raw level stays stable.
- `IN` is high during the cycle after edge `DEB_N`+2.
- `TOK` timing, with edge 0 as the first edge sampling `Run` = 1:
  - `TOK` is high after edges `T_TOK`−1, 2·`T_TOK`−1, and so on, one cycle each.
  - `TokCnt` updates on the same edge as `TOK`.
- A reset asserted mid-operation takes effect at the next edge and overrides all other events.
- Sensor and button paths are independent of `Run`.

## Structure
- **Shared package `mezcla_pkg`:**
  - default `DEB_N`, `T_TOK`, `CW`
  - timer state encoding (IDLE = 1'b0, COUNT = 1'b1)
- **Sub-module `antirrebote`:** synchronizer plus debouncer, parameterized by `DEB_N` and `CW`. Instantiated three times (button, P1, P2).
- **Top-level logic:** one-shot and timer FSM.

## Test plan
All scenarios use `DEB_N` = 4, `T_TOK` = 10.
- **Sensor debounce:** `P1Raw` = 1 held from reset release → `P1` = 0 through edge 4, `P1` = 1 after edge 5; `P2` stays 0.
- **Glitch rejection:** `P2Raw` pulse of 3 cycles → `P2` stays 0, and its debounce counter returns to 0.
- **Start pulse:** `BtnRaw` 0 for 10 cycles, then 1 for 30 → exactly one `IN` pulse, high after edge 6; no pulse on release.
- **Button held through reset:** `BtnRaw` = 1 before and after reset → no `IN`. Release for 8 cycles, then press → one `IN` pulse.
- **Token train:** `Run` = 1 for 45 cycles:
  - `TOK` after edges 9, 19, 29, 39.
  - `TokCnt` = 1, 2, 3, 3.
  - Dropping `Run` → `TokCnt` = 0 next cycle.
- **Run drop at terminal / reset mid-count:**
  - `Run` falls on the edge where count would reach 10 → no `TOK`. Re-raising `Run` gives the next `TOK` after a further 10 samples.
  - `Reset` at count 5 → all outputs 0 on the next edge.
